axicb_grant_tracker: RTL

Response-side companion to the crossbar's priority round-robin arbiter. The arbiter decides which requester owns a slave port; this block records the order of those grants. It then steers the slave's returning responses back to the matching requester, in grant order. One instance sits on each slave port, behind the arbiter, on the response path.

---
 rtl/axicb_pkg.sv | 34 +++
 rtl/axicb_grant_fifo.sv | 71 +++++++
 rtl/axicb_grant_tracker.sv | 77 +++++++
 3 files changed

// File: rtl/axicb_pkg.sv
// Shared types and helpers for the crossbar grant-tracking logic.
package axicb_pkg;

    // Widest grant vector the encoder handles (REQ_NB is limited to 16).
    localparam int ONEHOT_MAX = 16;

    typedef struct packed {
        logic       valid;  // exactly one bit was set
        logic [3:0] idx;    // position of the lowest set bit
    } onehot_idx_t;

    // Width of a stored requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Encode a one-hot vector. The lowest set bit wins, so a malformed grant
    // still maps to a deterministic requester.
    function automatic onehot_idx_t onehot_to_idx(input logic [ONEHOT_MAX-1:0] vec);
        onehot_idx_t res;
        int          ones;
        res.idx = '0;
        ones    = 0;
        for (int i = ONEHOT_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.idx = 4'(i);
                ones++;
            end
        end
        res.valid = (ones == 1);
        return res;
    endfunction

endpackage

// File: rtl/axicb_grant_fifo.sv
// DEPTH x WIDTH synchronous fifo holding granted requester indices in grant order.
// Fullness is tracked with an occupancy counter, so the pointers can simply wrap.
module axicb_grant_fifo
    import axicb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for pointers and occupancy; push and pop together leave the count alone.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers with synchronous reset.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge aclk) begin
        // NOTE: the array is deliberately not reset; the counter alone says which entries are live.
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axicb_grant_tracker.sv
// Records arbiter grants in order and steers slave responses back to the
// requester that owns the oldest outstanding grant.
module axicb_grant_tracker
    import axicb_pkg::*;
#(
    parameter int REQ_NB = 4,
    parameter int DEPTH  = 8
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     grant_valid,
    input  logic [REQ_NB-1:0]        grant,
    output logic                     grant_ready,
    input  logic                     rsp_valid,
    input  logic                     rsp_last,
    output logic                     rsp_ready,
    output logic [REQ_NB-1:0]        out_valid,
    input  logic [REQ_NB-1:0]        out_ready,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     onehot_err
);

    localparam int IDX_W = idx_width(REQ_NB);

    logic [ONEHOT_MAX-1:0] grant_ext;
    onehot_idx_t           enc;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      head_idx;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic                  onehot_err_q;

    assign grant_ext   = ONEHOT_MAX'(grant);
    assign enc         = onehot_to_idx(grant_ext);
    assign grant_idx   = IDX_W'(enc.idx);
    assign grant_ready = ~fifo_full;
    assign push        = grant_valid & grant_ready;
    // rsp_ready is already forced low when empty, so no pop can occur then.
    assign pop         = rsp_valid & rsp_ready & rsp_last;
    assign onehot_err  = onehot_err_q;

    axicb_grant_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .aclk    (aclk),
        .srst    (srst),
        .push_i  (push),
        .data_i  (grant_idx),
        .pop_i   (pop),
        .head_o  (head_idx),
        .count_o (outstanding),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Steer the response beat to the head requester; nothing is routed while empty.
    always_comb begin
        out_valid = '0;
        rsp_ready = 1'b0;
        if (!fifo_empty) begin
            for (int r = 0; r < REQ_NB; r++) begin
                if (head_idx == IDX_W'(r)) begin
                    out_valid[r] = rsp_valid;
                    rsp_ready    = out_ready[r];
                end
            end
        end
    end

    // Sticky malformed-grant flag, cleared only by reset.
    always_ff @(posedge aclk) begin
        if (srst)                     onehot_err_q <= 1'b0;
        else if (push && !enc.valid)  onehot_err_q <= 1'b1;
    end

endmodule
